// File: rtl/acc_pkg.sv
// acc_pkg: opcodes, flag bit positions and FSM states shared by the accumulator bank
package acc_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LOAD = 4'd1;
    localparam logic [3:0] OP_CLR  = 4'd2;
    localparam logic [3:0] OP_ADD  = 4'd3;
    localparam logic [3:0] OP_SUB  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SHL  = 4'd8;
    localparam logic [3:0] OP_SHR  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    localparam int F_Z = 0;
    localparam int F_C = 1;
    localparam int F_N = 2;
    localparam int F_V = 3;

    typedef enum logic {S_IDLE, S_MUL} state_t;

endpackage

// File: rtl/acc_mul_seq.sv
// acc_mul_seq: iterative shift-add multiplier, one multiplier bit per cycle, WIDTH cycles per product
module acc_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;

    assign p    = prod + (mplier[0] ? mcand : '0);
    assign done = busy && (cnt == CW'(WIDTH - 1));

    // latch operands on start, then accumulate one partial product per cycle
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mcand  <= '0;
            prod   <= '0;
            mplier <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            prod   <= '0;
            mplier <= b;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            prod   <= p;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            busy   <= !done;
        end
    end

endmodule

// File: rtl/acc_bank.sv
// acc_bank: NUM_ACC x WIDTH accumulator bank with ALU ops, registered read port and flags; ACC_MUL_EN adds a multi-cycle MUL
module acc_bank
    import acc_pkg::*;
#(
    parameter  int WIDTH   = 8,
    parameter  int NUM_ACC = 4,
    localparam int SELW    = $clog2(NUM_ACC)
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             OP_VALID,
    output logic             OP_READY,
    input  logic [3:0]       OP,
    input  logic [SELW-1:0]  SEL,
    input  logic [WIDTH-1:0] Bus_in,
    input  logic             OE,
    input  logic [SELW-1:0]  RD_SEL,
    output logic [WIDTH-1:0] Acc_out,
    output logic [3:0]       FLAGS
);

    logic [WIDTH-1:0] acc [NUM_ACC];
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] res;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic             c;
    logic             v;
    logic             we;
    logic [3:0]       nf;
    logic             mul_wr;
    logic [SELW-1:0]  msel;
    logic [WIDTH-1:0] mres;
    logic [3:0]       mflags;

    // single-cycle ALU: result and flags for the op presented on the bus
    always_comb begin
        cur = acc[SEL];
        sum = {1'b0, cur} + {1'b0, Bus_in};
        dif = {1'b0, cur} - {1'b0, Bus_in};
        res = cur;
        c   = 1'b0;
        v   = 1'b0;
        we  = 1'b1;
        case (OP)
            OP_LOAD: res = Bus_in;
            OP_CLR:  res = '0;
            OP_ADD: begin
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (cur[WIDTH-1] == Bus_in[WIDTH-1]) && (sum[WIDTH-1] != cur[WIDTH-1]);
            end
            OP_SUB: begin
                res = dif[WIDTH-1:0];
                c   = dif[WIDTH];
                v   = (cur[WIDTH-1] != Bus_in[WIDTH-1]) && (dif[WIDTH-1] != cur[WIDTH-1]);
            end
            OP_AND:  res = cur & Bus_in;
            OP_OR:   res = cur | Bus_in;
            OP_XOR:  res = cur ^ Bus_in;
            OP_SHL: begin
                res = {cur[WIDTH-2:0], 1'b0};
                c   = cur[WIDTH-1];
            end
            OP_SHR: begin
                res = {1'b0, cur[WIDTH-1:1]};
                c   = cur[0];
            end
            default: we = 1'b0;
        endcase
        nf       = '0;
        nf[F_Z]  = (res == '0);
        nf[F_C]  = c;
        nf[F_N]  = res[WIDTH-1];
        nf[F_V]  = v;
    end

`ifdef ACC_MUL_EN
    state_t             state;
    state_t             nstate;
    logic               start;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] p;

    acc_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .start   (start),
        .a       (cur),
        .b       (Bus_in),
        .busy    (busy),
        .done    (done),
        .p       (p)
    );

    assign mres          = p[WIDTH-1:0];
    assign mflags[F_Z]   = (p[WIDTH-1:0] == '0);
    assign mflags[F_C]   = |p[2*WIDTH-1:WIDTH];
    assign mflags[F_N]   = p[WIDTH-1];
    assign mflags[F_V]   = 1'b0;

    // FSM state register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= S_IDLE;
        else          state <= nstate;
    end

    // remember which accumulator the running multiply writes back to
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)   msel <= '0;
        else if (start) msel <= SEL;
    end

    // next state, handshake and write-back strobe
    always_comb begin
        nstate   = state;
        OP_READY = 1'b1;
        start    = 1'b0;
        mul_wr   = 1'b0;
        if (state == S_IDLE) begin
            start  = OP_VALID && (OP == OP_MUL);
            nstate = start ? S_MUL : S_IDLE;
        end else begin
            OP_READY = 1'b0;
            mul_wr   = done;
            nstate   = (done || !busy) ? S_IDLE : S_MUL;
        end
    end
`else
    assign OP_READY = 1'b1;
    assign mul_wr   = 1'b0;
    assign msel     = '0;
    assign mres     = '0;
    assign mflags   = '0;
`endif

    // register array and flags: multiply write-back or accepted single-cycle op
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
            FLAGS <= '0;
        end else if (mul_wr) begin
            acc[msel] <= mres;
            FLAGS     <= mflags;
        end else if (OP_VALID && OP_READY && we) begin
            acc[SEL] <= res;
            FLAGS    <= nf;
        end
    end

    // registered read port sees the pre-edge register contents
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) Acc_out <= '0;
        else          Acc_out <= OE ? acc[RD_SEL] : '0;
    end

endmodule
